dvp_capture_win: RTL and testbench

- Parametrised successor to the camera DVP capture stage. Sits between the OV5640 DVP pins and the SDRAM controller write port 1.
- Adds start-up frame skip, runtime frame decimation, a runtime crop window, and an RGB565 / GRAY8 input mode.
- GRAY8 input is expanded to RGB565 so the SDRAM and display path stay unchanged.
- All logic runs on the camera pixel clock.

---
 rtl/dvp_capture_win.sv | 238 +++++++++++++++++++++++
 tb/tb_dvp_capture_win.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_capture_win.sv
// DVP camera capture with start-up frame skip, frame decimation, crop window
// and RGB565/GRAY8 input, producing RGB565 pixels for the SDRAM write port.
module dvp_capture_win #(
    parameter int unsigned MAX_W       = 2048,
    parameter int unsigned MAX_H       = 2048,
    parameter int unsigned SKIP_FRAMES = 10,
    parameter int unsigned FCNT_W      = 16,
    localparam int unsigned XW         = $clog2(MAX_W),
    localparam int unsigned YW         = $clog2(MAX_H)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Vsync,
    input  logic              Href,
    input  logic [7:0]        Data,
    input  logic              cfg_mode,
    input  logic [3:0]        cfg_decim,
    input  logic [XW-1:0]     cfg_x0,
    input  logic [YW-1:0]     cfg_y0,
    input  logic [XW:0]       cfg_w,
    input  logic [YW:0]       cfg_h,
    output logic              ImageState,
    output logic              FrameStart,
    output logic              DataValid,
    output logic [15:0]       DataPixel,
    output logic [XW-1:0]     Xaddr,
    output logic [YW-1:0]     Yaddr,
    output logic [FCNT_W-1:0] FrameCnt
);

    localparam int unsigned SKW = $clog2(SKIP_FRAMES + 2);
    localparam int unsigned XE  = XW + 2;
    localparam int unsigned YE  = YW + 2;
    localparam logic [XW-1:0] X_MAX = XW'(MAX_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(MAX_H - 1);

    typedef enum logic [1:0] {S_WAIT, S_SKIP, S_RUN} state_t;

    logic          r_vs, r_vs_d, r_href, r_href_d;
    logic [7:0]    r_data;
    state_t        r_state, w_state_nxt;
    logic [SKW-1:0] r_skip_cnt, w_skip_nxt;
    logic          w_frame_start;
    logic [3:0]    r_dec_cnt;
    logic          r_frame_en;
    logic          r_sh_mode;
    logic [XW-1:0] r_sh_x0;
    logic [YW-1:0] r_sh_y0;
    logic [XW:0]   r_sh_w;
    logic [YW:0]   r_sh_h;
    logic [XW-1:0] r_xcnt;
    logic [YW-1:0] r_ycnt;
    logic          r_phase;
    logic [7:0]    r_hi;
    logic          r_s1_vld;
    logic [15:0]   r_s1_pix;
    logic [XW-1:0] r_s1_x;
    logic [YW-1:0] r_s1_y;

    logic          w_vs_rise, w_href_rise, w_href_fall;
    logic [XW-1:0] w_x_cur, w_x_inc;
    logic          w_phase_cur, w_byte_vld, w_pix_done, w_in_x, w_in_y, w_emit;
    logic [15:0]   w_pix;

    // Input register stage and edge history
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_vs     <= 1'b0;
            r_vs_d   <= 1'b0;
            r_href   <= 1'b0;
            r_href_d <= 1'b0;
            r_data   <= 8'h00;
        end else begin
            r_vs     <= Vsync;
            r_vs_d   <= r_vs;
            r_href   <= Href;
            r_href_d <= r_href;
            r_data   <= Data;
        end
    end

    assign w_vs_rise   = r_vs & ~r_vs_d;
    assign w_href_rise = r_href & ~r_href_d;
    assign w_href_fall = ~r_href & r_href_d;

    // Capture state register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state    <= S_WAIT;
            r_skip_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_skip_cnt <= w_skip_nxt;
        end
    end

    // The vs_rise that enters RUN is itself the first RUN frame start
    always_comb begin
        w_state_nxt   = r_state;
        w_skip_nxt    = r_skip_cnt;
        w_frame_start = 1'b0;
        case (r_state)
            S_WAIT: begin
                if (w_vs_rise) begin
                    if (SKIP_FRAMES == 0) begin
                        w_state_nxt   = S_RUN;
                        w_frame_start = 1'b1;
                    end else begin
                        w_state_nxt = S_SKIP;
                        w_skip_nxt  = '0;
                    end
                end
            end
            S_SKIP: begin
                if (w_vs_rise) begin
                    if (SKW'(r_skip_cnt + SKW'(1)) == SKW'(SKIP_FRAMES)) begin
                        w_state_nxt   = S_RUN;
                        w_skip_nxt    = '0;
                        w_frame_start = 1'b1;
                    end else begin
                        w_skip_nxt = SKW'(r_skip_cnt + SKW'(1));
                    end
                end
            end
            S_RUN: begin
                w_frame_start = w_vs_rise;
            end
            default: begin
                w_state_nxt = S_WAIT;
                w_skip_nxt  = '0;
            end
        endcase
    end

    // Frame start: shadow the config, step decimation, count captured frames
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_dec_cnt  <= 4'd0;
            r_frame_en <= 1'b0;
            r_sh_mode  <= 1'b0;
            r_sh_x0    <= '0;
            r_sh_y0    <= '0;
            r_sh_w     <= '0;
            r_sh_h     <= '0;
            FrameStart <= 1'b0;
            FrameCnt   <= '0;
            ImageState <= 1'b1;
        end else begin
            ImageState <= (w_state_nxt != S_RUN);
            FrameStart <= 1'b0;
            if (w_frame_start) begin
                r_sh_mode  <= cfg_mode;
                r_sh_x0    <= cfg_x0;
                r_sh_y0    <= cfg_y0;
                r_sh_w     <= cfg_w;
                r_sh_h     <= cfg_h;
                r_frame_en <= (r_dec_cnt == 4'd0);
                r_dec_cnt  <= (r_dec_cnt >= cfg_decim) ? 4'd0 : 4'(r_dec_cnt + 4'd1);
                if (r_dec_cnt == 4'd0) begin
                    FrameStart <= 1'b1;
                    FrameCnt   <= FCNT_W'(FrameCnt + FCNT_W'(1));
                end
            end
        end
    end

    // A rising href restarts the line even if the previous one ended on an odd byte
    assign w_x_cur     = w_href_rise ? '0 : r_xcnt;
    assign w_phase_cur = w_href_rise ? 1'b0 : r_phase;
    assign w_byte_vld  = r_href & ~r_vs;
    assign w_pix_done  = w_byte_vld & (r_sh_mode | w_phase_cur);
    assign w_x_inc     = (w_x_cur == X_MAX) ? w_x_cur : XW'(w_x_cur + XW'(1));
    assign w_pix       = r_sh_mode ? {r_data[7:3], r_data[7:2], r_data[7:3]}
                                   : {r_hi, r_data};

    // Line and pixel position counters
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_xcnt  <= '0;
            r_ycnt  <= '0;
            r_phase <= 1'b0;
            r_hi    <= 8'h00;
        end else if (r_vs) begin
            r_xcnt  <= '0;
            r_ycnt  <= '0;
            r_phase <= 1'b0;
        end else begin
            if (w_byte_vld) begin
                if (w_pix_done) begin
                    r_xcnt  <= w_x_inc;
                    r_phase <= 1'b0;
                end else begin
                    r_xcnt  <= w_x_cur;
                    r_phase <= 1'b1;
                    r_hi    <= r_data;
                end
            end
            if (w_href_fall && (r_ycnt != Y_MAX)) begin
                r_ycnt <= YW'(r_ycnt + YW'(1));
            end
        end
    end

    // Window limits are summed two bits wide so an oversize window clips
    assign w_in_x = (w_x_cur >= r_sh_x0) &&
                    (XE'(w_x_cur) < XE'(XE'(r_sh_x0) + XE'(r_sh_w)));
    assign w_in_y = (r_ycnt >= r_sh_y0) &&
                    (YE'(r_ycnt) < YE'(YE'(r_sh_y0) + YE'(r_sh_h)));
    assign w_emit = w_pix_done && (r_state == S_RUN) && r_frame_en && w_in_x && w_in_y;

    // Two-stage output pipeline; pixel fields hold between strobes
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_pix  <= 16'h0000;
            r_s1_x    <= '0;
            r_s1_y    <= '0;
            DataValid <= 1'b0;
            DataPixel <= 16'h0000;
            Xaddr     <= '0;
            Yaddr     <= '0;
        end else begin
            r_s1_vld  <= w_emit;
            DataValid <= r_s1_vld;
            if (w_emit) begin
                r_s1_pix <= w_pix;
                r_s1_x   <= XW'(w_x_cur - r_sh_x0);
                r_s1_y   <= YW'(r_ycnt - r_sh_y0);
            end
            if (r_s1_vld) begin
                DataPixel <= r_s1_pix;
                Xaddr     <= r_s1_x;
                Yaddr     <= r_s1_y;
            end
        end
    end

endmodule

// File: tb/tb_dvp_capture_win.sv
// Directed bench for dvp_capture_win: 8x4 frames, SKIP_FRAMES=2, table of window/mode cases.
module tb_dvp_capture_win;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Vsync;
    logic        Href;
    logic [7:0]  Data;
    logic        cfg_mode;
    logic [3:0]  cfg_decim;
    logic [2:0]  cfg_x0;
    logic [1:0]  cfg_y0;
    logic [3:0]  cfg_w;
    logic [2:0]  cfg_h;
    logic        ImageState;
    logic        FrameStart;
    logic        DataValid;
    logic [15:0] DataPixel;
    logic [2:0]  Xaddr;
    logic [1:0]  Yaddr;
    logic [15:0] FrameCnt;

    dvp_capture_win #(
        .MAX_W(8), .MAX_H(4), .SKIP_FRAMES(2), .FCNT_W(16)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Vsync(Vsync), .Href(Href), .Data(Data),
        .cfg_mode(cfg_mode), .cfg_decim(cfg_decim), .cfg_x0(cfg_x0),
        .cfg_y0(cfg_y0), .cfg_w(cfg_w), .cfg_h(cfg_h),
        .ImageState(ImageState), .FrameStart(FrameStart), .DataValid(DataValid),
        .DataPixel(DataPixel), .Xaddr(Xaddr), .Yaddr(Yaddr), .FrameCnt(FrameCnt)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        mode;
        logic [3:0]  decim;
        logic [2:0]  x0;
        logic [1:0]  y0;
        logic [3:0]  w;
        logic [2:0]  h;
        int          nl;
        int          nb;
        int          nfr;
        int          exp_n;
        int          exp_fs;
        logic [15:0] f_pix;
        int          f_x;
        int          f_y;
        logic [15:0] l_pix;
        int          l_x;
        int          l_y;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_strobe = 0;
    int          n_fs = 0;
    int          exp_fcnt = 0;
    logic        img_before, img_at;
    logic [15:0] log_pix [1024];
    int          log_x   [1024];
    int          log_y   [1024];

    // Strobe logger, sampled on the inactive edge
    always @(negedge Clk) begin
        if (DataValid) begin
            log_pix[n_strobe % 1024] = DataPixel;
            log_x[n_strobe % 1024]   = int'(Xaddr);
            log_y[n_strobe % 1024]   = int'(Yaddr);
            n_strobe = n_strobe + 1;
        end
        if (FrameStart) n_fs = n_fs + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gen(input int y, input int b);
        return 8'((y << 4) | b);
    endfunction

    // One frame: vsync pulse, nl lines of nb bytes; optional x0 change after line 0
    task automatic run_frame(input int nl, input int nb, input bit chg, input logic [2:0] nx0);
        img_before = ImageState;
        Vsync = 1'b1;
        repeat (3) @(negedge Clk);
        img_at = ImageState;
        Vsync = 1'b0;
        repeat (3) @(negedge Clk);
        for (int y = 0; y < nl; y++) begin
            for (int b = 0; b < nb; b++) begin
                Href = 1'b1;
                Data = gen(y, b);
                @(negedge Clk);
            end
            Href = 1'b0;
            Data = 8'h00;
            if (chg && y == 0) cfg_x0 = nx0;
            repeat (3) @(negedge Clk);
        end
        repeat (4) @(negedge Clk);
    endtask

    task automatic set_cfg(input logic m, input logic [3:0] d, input logic [2:0] x0,
                           input logic [1:0] y0, input logic [3:0] w, input logic [2:0] h);
        cfg_mode = m; cfg_decim = d; cfg_x0 = x0; cfg_y0 = y0; cfg_w = w; cfg_h = h;
    endtask

    vec_t vt [6];

    initial begin
        int base;
        int fsb;

        vt[0] = '{1'b0, 4'd0, 3'd2, 2'd1, 4'd3, 3'd2, 4, 16, 1,  6, 1, 16'h1415, 0, 0, 16'h2829, 2, 1};
        vt[1] = '{1'b1, 4'd0, 3'd0, 2'd0, 4'd8, 3'd4, 4,  8, 1, 32, 1, 16'h0000, 0, 0, 16'h31A6, 7, 3};
        vt[2] = '{1'b0, 4'd0, 3'd0, 2'd0, 4'd8, 3'd4, 4,  7, 1, 12, 1, 16'h0001, 0, 0, 16'h3435, 2, 3};
        vt[3] = '{1'b0, 4'd0, 3'd6, 2'd3, 4'd5, 3'd4, 4, 16, 1,  2, 1, 16'h3C3D, 0, 0, 16'h3E3F, 1, 0};
        vt[4] = '{1'b0, 4'd0, 3'd0, 2'd0, 4'd0, 3'd4, 4, 16, 1,  0, 1, 16'h0000, 0, 0, 16'h0000, 0, 0};
        vt[5] = '{1'b0, 4'd2, 3'd0, 2'd0, 4'd8, 3'd4, 4, 16, 6, 64, 2, 16'h0001, 0, 0, 16'h3E3F, 7, 3};

        Rst = 1'b1; Vsync = 1'b0; Href = 1'b0; Data = 8'h00;
        set_cfg(1'b0, 4'd0, 3'd0, 2'd0, 4'd8, 3'd4);
        repeat (3) @(negedge Clk);
        chk("rst_imagestate", int'(ImageState), 1);
        chk("rst_datavalid",  int'(DataValid), 0);
        chk("rst_framestart", int'(FrameStart), 0);
        chk("rst_pixel",      int'(DataPixel), 0);
        chk("rst_xaddr",      int'(Xaddr), 0);
        chk("rst_yaddr",      int'(Yaddr), 0);
        chk("rst_framecnt",   int'(FrameCnt), 0);
        Rst = 1'b0;
        @(negedge Clk);

        // Start-up skip: frames 1-2 discarded, 3-4 captured
        for (int f = 0; f < 4; f++) begin
            base = n_strobe;
            run_frame(4, 16, 1'b0, 3'd0);
            chk($sformatf("skip_f%0d_strobes", f + 1), n_strobe - base, (f < 2) ? 0 : 32);
            chk($sformatf("skip_f%0d_imgstate", f + 1), int'(img_at), (f < 2) ? 1 : 0);
            if (f == 2) begin
                chk("skip_f3_img_before", int'(img_before), 1);
                chk("skip_f3_first_pix", int'(log_pix[base % 1024]), 16'h0001);
            end
            if (f == 3) begin
                chk("skip_f4_last_pix", int'(log_pix[(n_strobe - 1) % 1024]), 16'h3E3F);
                chk("skip_f4_last_x", log_x[(n_strobe - 1) % 1024], 7);
                chk("skip_f4_last_y", log_y[(n_strobe - 1) % 1024], 3);
            end
        end
        exp_fcnt = 2;
        chk("skip_framestart_cnt", n_fs, 2);
        chk("skip_framecnt", int'(FrameCnt), exp_fcnt);

        // RGB565 latency and hold
        Vsync = 1'b1; repeat (3) @(negedge Clk);
        Vsync = 1'b0; repeat (3) @(negedge Clk);
        Href = 1'b1; Data = 8'hF8; @(negedge Clk);
        Data = 8'h1F; @(negedge Clk);
        chk("lat_c0_dv", int'(DataValid), 0);
        Href = 1'b0; Data = 8'h00;
        @(negedge Clk);
        chk("lat_c1_dv", int'(DataValid), 0);
        @(negedge Clk);
        chk("lat_c2_dv", int'(DataValid), 1);
        chk("lat_pix", int'(DataPixel), 16'hF81F);
        chk("lat_x", int'(Xaddr), 0);
        chk("lat_y", int'(Yaddr), 0);
        @(negedge Clk);
        chk("lat_c3_dv", int'(DataValid), 0);
        chk("lat_hold_pix", int'(DataPixel), 16'hF81F);
        repeat (4) @(negedge Clk);
        exp_fcnt = exp_fcnt + 1;

        // GRAY8 expansion of a single byte
        cfg_mode = 1'b1;
        base = n_strobe;
        Vsync = 1'b1; repeat (3) @(negedge Clk);
        Vsync = 1'b0; repeat (3) @(negedge Clk);
        Href = 1'b1; Data = 8'hA5; @(negedge Clk);
        Href = 1'b0; Data = 8'h00;
        repeat (6) @(negedge Clk);
        chk("gray_a5_strobes", n_strobe - base, 1);
        chk("gray_a5_pix", int'(log_pix[base % 1024]), 16'hA534);
        exp_fcnt = exp_fcnt + 1;
        chk("gray_a5_framecnt", int'(FrameCnt), exp_fcnt);

        // Window / mode / decimation table
        for (int i = 0; i < 6; i++) begin
            set_cfg(vt[i].mode, vt[i].decim, vt[i].x0, vt[i].y0, vt[i].w, vt[i].h);
            base = n_strobe;
            fsb  = n_fs;
            for (int k = 0; k < vt[i].nfr; k++) run_frame(vt[i].nl, vt[i].nb, 1'b0, 3'd0);
            exp_fcnt = exp_fcnt + vt[i].exp_fs;
            chk($sformatf("row%0d_strobes", i), n_strobe - base, vt[i].exp_n);
            chk($sformatf("row%0d_framestart", i), n_fs - fsb, vt[i].exp_fs);
            chk($sformatf("row%0d_framecnt", i), int'(FrameCnt), exp_fcnt);
            if (vt[i].exp_n > 0 && n_strobe > base) begin
                chk($sformatf("row%0d_first_pix", i), int'(log_pix[base % 1024]), int'(vt[i].f_pix));
                chk($sformatf("row%0d_first_x", i), log_x[base % 1024], vt[i].f_x);
                chk($sformatf("row%0d_first_y", i), log_y[base % 1024], vt[i].f_y);
                chk($sformatf("row%0d_last_pix", i), int'(log_pix[(n_strobe - 1) % 1024]), int'(vt[i].l_pix));
                chk($sformatf("row%0d_last_x", i), log_x[(n_strobe - 1) % 1024], vt[i].l_x);
                chk($sformatf("row%0d_last_y", i), log_y[(n_strobe - 1) % 1024], vt[i].l_y);
            end
        end

        // Mid-frame cfg_x0 change applies only from the next frame
        set_cfg(1'b0, 4'd0, 3'd0, 2'd0, 4'd8, 3'd4);
        base = n_strobe;
        run_frame(4, 16, 1'b1, 3'd4);
        chk("midchg_f1_strobes", n_strobe - base, 32);
        chk("midchg_f1_first_pix", int'(log_pix[base % 1024]), 16'h0001);
        chk("midchg_f1_last_x", log_x[(n_strobe - 1) % 1024], 7);
        base = n_strobe;
        run_frame(4, 16, 1'b0, 3'd0);
        chk("midchg_f2_strobes", n_strobe - base, 16);
        chk("midchg_f2_first_pix", int'(log_pix[base % 1024]), 16'h0809);
        chk("midchg_f2_first_x", log_x[base % 1024], 0);
        chk("midchg_f2_last_x", log_x[(n_strobe - 1) % 1024], 3);
        exp_fcnt = exp_fcnt + 2;
        chk("midchg_framecnt", int'(FrameCnt), exp_fcnt);

        // Reset in the middle of a captured line
        cfg_x0 = 3'd0;
        Vsync = 1'b1; repeat (3) @(negedge Clk);
        Vsync = 1'b0; repeat (3) @(negedge Clk);
        for (int b = 0; b < 16; b++) begin
            Href = 1'b1; Data = gen(0, b); @(negedge Clk);
        end
        Href = 1'b0; repeat (3) @(negedge Clk);
        for (int b = 0; b < 5; b++) begin
            Href = 1'b1; Data = gen(1, b); @(negedge Clk);
        end
        Rst = 1'b1; Data = gen(1, 5);
        @(negedge Clk);
        chk("midrst_imagestate", int'(ImageState), 1);
        chk("midrst_datavalid", int'(DataValid), 0);
        chk("midrst_framestart", int'(FrameStart), 0);
        chk("midrst_pixel", int'(DataPixel), 0);
        chk("midrst_xaddr", int'(Xaddr), 0);
        chk("midrst_framecnt", int'(FrameCnt), 0);
        Rst = 1'b0; Href = 1'b0; Data = 8'h00;
        repeat (4) @(negedge Clk);
        for (int f = 0; f < 3; f++) begin
            base = n_strobe;
            run_frame(4, 16, 1'b0, 3'd0);
            chk($sformatf("postrst_f%0d_strobes", f + 1), n_strobe - base, (f < 2) ? 0 : 32);
        end
        chk("postrst_framecnt", int'(FrameCnt), 1);
        chk("postrst_imagestate", int'(ImageState), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
